// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
//   ST_*          : FSM state encodings (IDLE / REQ / WAIT)
//   MAX_WAIT_DEF  : default timeout budget in cycles
//   DW_DEF/AW_DEF : default data / address widths
package mem_access_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int MAX_WAIT_DEF = 15;
    localparam int DW_DEF       = 16;
    localparam int AW_DEF       = 16;

endpackage

// File: rtl/mem_access_ctrl_timeout_ctr.sv
// mem_timeout_ctr: cycle counter for an outstanding memory access.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count (request issued this cycle)
//   en       : count this cycle (access outstanding)
//   tc       : terminal count; high during the MAX_WAIT-th outstanding cycle
module mem_timeout_ctr #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    // cnt is 0 in the first cycle after issue, so it equals MAX_WAIT-1
    // during the MAX_WAIT-th outstanding cycle.
    assign tc = (cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage access controller feeding the M/W register.
// Issues one load/store per X/M instruction to a stalling data memory,
// freezes the upstream pipe until the access finishes, then presents a
// registered result. Non-memory instructions retire with 1-cycle latency.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   in_valid/in_mem_read/
//   in_mem_write/in_addr/in_wdata   : instruction from X/M (held stable while stall_out)
//   stall_out                       : freeze PC/F/D/X/M
//   mem_en/mem_wr/mem_addr/mem_wdata: memory request
//   mem_stall/mem_done/mem_rdata    : memory handshake and read data
//   wb_valid/wb_mem_data/wb_err     : registered result to M/W
//   busy                            : an access is outstanding (FSM not IDLE)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    output logic          stall_out,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_stall,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_valid,
    output logic [DW-1:0] wb_mem_data,
    output logic          wb_err,
    output logic          busy
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          mem_op;
    logic          aligned;
    logic          in_idle;
    logic          outstanding;
    logic          issue;
    logic          req_active;
    logic          complete;
    logic          timeout;
    logic          tc;
    logic          vld_p0;
    logic          err_p0;
    logic [DW-1:0] data_p0;

    assign mem_op      = in_valid & (in_mem_read | in_mem_write);
    assign aligned     = ~in_addr[0];
    assign in_idle     = (state == ST_IDLE);
    assign outstanding = (state == ST_REQ) || (state == ST_WAIT);

    // A request is on the bus either on the issue cycle or while held in REQ.
    assign issue      = in_idle & mem_op & aligned;
    assign req_active = issue | (state == ST_REQ);

    // mem_done counts only once the request has been accepted (same cycle
    // as acceptance, or later in WAIT); a done during a stalled request
    // or in IDLE is ignored.
    assign complete = (req_active & ~mem_stall & mem_done)
                    | ((state == ST_WAIT) & mem_done);
    assign timeout  = outstanding & tc & ~complete;

    // Request fields come straight from the held X/M slot. The enables are
    // gated by rst so the bus and the freeze drop the moment reset rises.
    assign mem_en    = ~rst & req_active & ~timeout;
    assign mem_wr    = in_mem_write;
    assign mem_addr  = in_addr;
    assign mem_wdata = in_wdata;

    // The instruction retires (stall released) on completion or timeout,
    // otherwise upstream would re-present it and it would be issued twice.
    assign stall_out = ~rst & ((issue & ~complete) | (outstanding & ~complete & ~timeout));
    assign busy      = ~in_idle;

    mem_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (issue),
        .en  (outstanding),
        .tc  (tc)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (issue && !complete) begin
                    state_nxt = mem_stall ? ST_REQ : ST_WAIT;
                end
            end
            ST_REQ: begin
                if (complete || timeout) begin
                    state_nxt = ST_IDLE;
                end else if (!mem_stall) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (complete || timeout) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result slot for the next M/W entry: retire non-mem, misaligned,
    // completed or timed-out instructions; a bubble otherwise.
    always_comb begin
        vld_p0  = 1'b0;
        err_p0  = 1'b0;
        data_p0 = '0;
        if (in_idle && in_valid && !mem_op) begin
            vld_p0 = 1'b1;
        end else if (in_idle && mem_op && !aligned) begin
            vld_p0 = 1'b1;
            err_p0 = 1'b1;
        end else if (complete) begin
            vld_p0  = 1'b1;
            data_p0 = in_mem_read ? mem_rdata : '0;
        end else if (timeout) begin
            vld_p0 = 1'b1;
            err_p0 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- stage boundary: M -> M/W register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_err      <= 1'b0;
            wb_mem_data <= '0;
        end else begin
            wb_valid    <= vld_p0;
            wb_err      <= err_p0;
            wb_mem_data <= data_p0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [15:0] in_addr, in_wdata;
    logic        stall_out, mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_stall, mem_done;
    logic [15:0] mem_rdata;
    logic        wb_valid, wb_err, busy;
    logic [15:0] wb_mem_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DW(16), .AW(16), .MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .stall_out    (stall_out),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_mem_data  (wb_mem_data),
        .wb_err       (wb_err),
        .busy         (busy)
    );

    typedef struct {
        string       name;
        logic        v, rd, wr;
        logic [15:0] addr, wdata;
        logic        ms, md;
        logic [15:0] rdata;
        logic        e_en, e_st, e_wbv, e_err;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic ms, input logic md, input logic [15:0] rdata);
        in_valid     = v;
        in_mem_read  = rd;
        in_mem_write = wr;
        in_addr      = addr;
        in_wdata     = wdata;
        mem_stall    = ms;
        mem_done     = md;
        mem_rdata    = rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        int en_cnt;
        int bad_wbv;
        bit done_seen;

        //               name          v  rd wr addr      wdata     ms md rdata     en st wbv err data
        vecs[0] = '{"idle_novalid",   0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000};
        vecs[1] = '{"nonmem_add",     1, 0, 0, 16'h1235, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000};
        vecs[2] = '{"load_hit",       1, 1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 1, 0, 1, 0, 16'hBEEF};
        vecs[3] = '{"store_odd",      1, 0, 1, 16'h0031, 16'h5A5A, 0, 0, 16'h0000, 0, 0, 1, 1, 16'h0000};
        vecs[4] = '{"store_hit",      1, 0, 1, 16'h0050, 16'h1111, 0, 1, 16'hAAAA, 1, 0, 1, 0, 16'h0000};
        vecs[5] = '{"load_odd_done",  1, 1, 0, 16'h0013, 16'h0000, 0, 1, 16'h5555, 0, 0, 1, 1, 16'h0000};
        vecs[6] = '{"stray_done",     0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h7777, 0, 0, 0, 0, 16'h0000};

        // Reset with an aligned load presented: nothing may leak out.
        rst = 1'b1;
        drive(1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000);
        #12;
        chk("rst_mem_en",    mem_en,      0);
        chk("rst_stall",     stall_out,   0);
        chk("rst_busy",      busy,        0);
        chk("rst_wb_valid",  wb_valid,    0);
        chk("rst_wb_err",    wb_err,      0);
        chk("rst_wb_data",   wb_mem_data, 0);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-cycle cases, applied back to back.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].ms, vecs[i].md, vecs[i].rdata);
            @(negedge clk);
            chk({vecs[i].name, "_mem_en"}, mem_en,    vecs[i].e_en);
            chk({vecs[i].name, "_stall"},  stall_out, vecs[i].e_st);
            if (vecs[i].e_en) begin
                chk({vecs[i].name, "_mem_addr"}, mem_addr, vecs[i].addr);
                chk({vecs[i].name, "_mem_wr"},   mem_wr,   vecs[i].wr);
            end
            @(posedge clk); #1;
            chk({vecs[i].name, "_wb_valid"}, wb_valid,    vecs[i].e_wbv);
            chk({vecs[i].name, "_wb_err"},   wb_err,      vecs[i].e_err);
            chk({vecs[i].name, "_wb_data"},  wb_mem_data, vecs[i].e_data);
        end

        // Load 0x0020: memory stalls 2 cycles (with a done during REQ that must
        // be ignored), accepts on cycle 2, completes on cycle 5.
        stall_cnt = 0; en_cnt = 0; bad_wbv = 0; done_seen = 0;
        drive(1, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000);
        for (int k = 0; k < 20 && !done_seen; k++) begin
            mem_stall = (k < 2);
            mem_done  = (k == 1) || (k == 5);
            mem_rdata = (k == 1) ? 16'hDEAD : ((k == 5) ? 16'h1234 : 16'h0000);
            @(negedge clk);
            if (stall_out) stall_cnt++;
            if (mem_en)    en_cnt++;
            if (k == 3)    chk("miss_busy_k3", busy, 1);
            if (!stall_out) done_seen = 1;
            @(posedge clk); #1;
            if (!done_seen && wb_valid) bad_wbv++;
        end
        chk("miss_stall_cycles", stall_cnt,   5);
        chk("miss_en_cycles",    en_cnt,      3);
        chk("miss_bubble_wbv",   bad_wbv,     0);
        chk("miss_wb_valid",     wb_valid,    1);
        chk("miss_wb_err",       wb_err,      0);
        chk("miss_wb_data",      wb_mem_data, 16'h1234);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(posedge clk); #1;
        chk("miss_after_wbv", wb_valid, 0);

        // Store 0x0040 with no mem_done: times out after 15 stalled cycles.
        stall_cnt = 0; en_cnt = 0; done_seen = 0;
        drive(1, 0, 1, 16'h0040, 16'h7777, 0, 0, 16'h0000);
        for (int k = 0; k < 40 && !done_seen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("to_mem_wr",    mem_wr,    1);
                chk("to_mem_wdata", mem_wdata, 16'h7777);
            end
            if (stall_out) stall_cnt++;
            if (mem_en)    en_cnt++;
            if (!stall_out) done_seen = 1;
            @(posedge clk); #1;
        end
        chk("to_stall_cycles", stall_cnt,   15);
        chk("to_en_cycles",    en_cnt,      1);
        chk("to_wb_valid",     wb_valid,    1);
        chk("to_wb_err",       wb_err,      1);
        chk("to_wb_data",      wb_mem_data, 0);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h9999);
        @(negedge clk);
        chk("late_done_mem_en", mem_en, 0);
        chk("late_done_busy",   busy,   0);
        @(posedge clk); #1;
        chk("late_done_wbv", wb_valid, 0);

        // Reset while in WAIT, then a normal load.
        drive(1, 1, 0, 16'h0060, 16'h0000, 0, 0, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy",  busy,      1);
        chk("pre_rst_stall", stall_out, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_mem_en",  mem_en,      0);
        chk("midrst_stall",   stall_out,   0);
        chk("midrst_busy",    busy,        0);
        chk("midrst_wbv",     wb_valid,    0);
        chk("midrst_wb_err",  wb_err,      0);
        chk("midrst_wb_data", wb_mem_data, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_wbv", wb_valid, 0);
        drive(1, 1, 0, 16'h0070, 16'h0000, 0, 1, 16'hCAFE);
        @(negedge clk);
        chk("post_rst_mem_en", mem_en,    1);
        chk("post_rst_stall",  stall_out, 0);
        @(posedge clk); #1;
        chk("post_rst_wbv",    wb_valid,    1);
        chk("post_rst_wb_data", wb_mem_data, 16'hCAFE);
        drive(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
